// File: rtl/hmmm_ctrl_if.sv
// Control bundle between the Hmmm sequencer (master) and the datapath/memory (slave).
// HMMM_CTRL_INSTRET_EN adds the retired-instruction count to the bundle.
interface hmmm_ctrl_if;
   logic [15:0] ir_data;
   logic        flag_zero;
   logic        flag_neg;
   logic        mem_ack;
   logic        mem_req;
   logic        mem_we;
   logic        pc_out;
   logic        pc_in;
   logic        pc_inc;
   logic        mar_in;
   logic        ir_in;
   logic        ir_out;
   logic        rf_out;
   logic        rf_in;
   logic [3:0]  rf_sel;
   logic        alu_a_in;
   logic        alu_out;
   logic [3:0]  alu_op;
   logic        halted;
   logic        illegal;
`ifdef HMMM_CTRL_INSTRET_EN
   logic [15:0] instret;
`endif

   modport master (
      input  ir_data, flag_zero, flag_neg, mem_ack,
      output mem_req, mem_we, pc_out, pc_in, pc_inc, mar_in, ir_in, ir_out,
             rf_out, rf_in, rf_sel, alu_a_in, alu_out, alu_op, halted, illegal
`ifdef HMMM_CTRL_INSTRET_EN
      , output instret
`endif
   );

   modport slave (
      output ir_data, flag_zero, flag_neg, mem_ack,
      input  mem_req, mem_we, pc_out, pc_in, pc_inc, mar_in, ir_in, ir_out,
             rf_out, rf_in, rf_sel, alu_a_in, alu_out, alu_op, halted, illegal
`ifdef HMMM_CTRL_INSTRET_EN
      , input instret
`endif
   );
endinterface

// File: rtl/hmmm_ctrl.sv
// Hmmm CPU multi-cycle control sequencer: fetch/decode/execute over a shared 16-bit bus.
// Define HMMM_CTRL_INSTRET_EN to add the 16-bit retired-instruction counter.
module hmmm_ctrl #(
   parameter int ILLEGAL_HALTS = 1
) (
   input  logic        clk,
   input  logic        rst,
   hmmm_ctrl_if.master ctl
);

   typedef enum logic [3:0] {
      FETCH_A,
      FETCH_M,
      DECODE,
      EXEC,
      MEM,
      ALU_WB,
      RA_WB,
      CALL_JMP,
      HALT
   } state_t;

   state_t state, next_state;

   logic [3:0] opcode, rx, ry, low_nib;
   logic [7:0] low_byte;

   logic is_halt, is_illegal, is_setn, is_load, is_store, is_mem_reg;
   logic is_alu, is_branch, is_calln, is_jumpr, taken;

   logic       mem_req, mem_we, pc_out, pc_in, pc_inc, mar_in, ir_in, ir_out;
   logic       rf_out, rf_in, alu_a_in, alu_out, halted;
   logic [3:0] rf_sel, alu_op;
   logic       illegal;

   assign opcode   = ctl.ir_data[15:12];
   assign rx       = ctl.ir_data[11:8];
   assign ry       = ctl.ir_data[7:4];
   assign low_byte = ctl.ir_data[7:0];
   assign low_nib  = ctl.ir_data[3:0];

   // read/write are folded into loadn/storen; the datapath substitutes I/O address 0xFF for opcode 0.
   always_comb begin
      is_halt    = (ctl.ir_data == 16'h0000);
      is_illegal = ((opcode == 4'h0) && (low_byte > 8'h03)) ||
                   ((opcode == 4'h4) && (low_nib > 4'h1));
      is_setn    = (opcode == 4'h1);
      is_load    = (opcode == 4'h2) ||
                   ((opcode == 4'h0) && (low_byte == 8'h01)) ||
                   ((opcode == 4'h4) && (low_nib == 4'h0));
      is_store   = (opcode == 4'h3) ||
                   ((opcode == 4'h0) && (low_byte == 8'h02)) ||
                   ((opcode == 4'h4) && (low_nib == 4'h1));
      is_mem_reg = (opcode == 4'h4);
      is_alu     = (opcode >= 4'h5) && (opcode <= 4'hA);
      is_branch  = (opcode >= 4'hB);
      is_calln   = (opcode == 4'hB) && (rx != 4'h0);
      is_jumpr   = (opcode == 4'h0) && (low_byte == 8'h03);
      taken      = 1'b0;
      case (opcode)
         4'hB:    taken = 1'b1;
         4'hC:    taken = ctl.flag_zero;
         4'hD:    taken = !ctl.flag_zero;
         4'hE:    taken = !ctl.flag_zero && !ctl.flag_neg;
         4'hF:    taken = ctl.flag_neg;
         default: taken = 1'b0;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= FETCH_A;
      end else begin
         state <= next_state;
      end
   end

   // Controls are forced low while rst is high so a pending mem_req drops without waiting for a clock.
   always_comb begin
      next_state = state;
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      pc_out     = 1'b0;
      pc_in      = 1'b0;
      pc_inc     = 1'b0;
      mar_in     = 1'b0;
      ir_in      = 1'b0;
      ir_out     = 1'b0;
      rf_out     = 1'b0;
      rf_in      = 1'b0;
      rf_sel     = 4'h0;
      alu_a_in   = 1'b0;
      alu_out    = 1'b0;
      alu_op     = 4'h0;
      halted     = 1'b0;
      if (!rst) begin
         case (state)
            FETCH_A: begin
               pc_out     = 1'b1;
               mar_in     = 1'b1;
               next_state = FETCH_M;
            end
            FETCH_M: begin
               mem_req = 1'b1;
               if (ctl.mem_ack) begin
                  ir_in      = 1'b1;
                  pc_inc     = 1'b1;
                  next_state = DECODE;
               end
            end
            DECODE: begin
               if (is_halt) begin
                  next_state = HALT;
               end else if (is_illegal) begin
                  next_state = (ILLEGAL_HALTS != 0) ? HALT : FETCH_A;
               end else begin
                  next_state = EXEC;
               end
            end
            EXEC: begin
               next_state = FETCH_A;
               if (is_setn) begin
                  ir_out = 1'b1;
                  rf_in  = 1'b1;
                  rf_sel = rx;
               end else if (is_load || is_store) begin
                  mar_in     = 1'b1;
                  next_state = MEM;
                  if (is_mem_reg) begin
                     rf_sel = ry;
                     rf_out = 1'b1;
                  end else begin
                     ir_out = 1'b1;
                  end
               end else if (is_alu) begin
                  rf_sel     = ry;
                  rf_out     = 1'b1;
                  alu_a_in   = 1'b1;
                  alu_op     = opcode;
                  next_state = ALU_WB;
               end else if (is_calln) begin
                  rf_sel     = rx;
                  next_state = RA_WB;
               end else if (is_branch) begin
                  rf_sel = rx;
                  if (taken) begin
                     ir_out = 1'b1;
                     pc_in  = 1'b1;
                  end
               end else if (is_jumpr) begin
                  rf_sel = rx;
                  rf_out = 1'b1;
                  pc_in  = 1'b1;
               end
            end
            MEM: begin
               mem_req = 1'b1;
               rf_sel  = rx;
               if (is_store) begin
                  mem_we = 1'b1;
                  rf_out = 1'b1;
               end
               if (ctl.mem_ack) begin
                  rf_in      = !is_store;
                  next_state = FETCH_A;
               end
            end
            ALU_WB: begin
               alu_out    = 1'b1;
               alu_op     = opcode;
               rf_in      = 1'b1;
               rf_sel     = rx;
               next_state = FETCH_A;
            end
            RA_WB: begin
               pc_out     = 1'b1;
               rf_in      = 1'b1;
               rf_sel     = rx;
               next_state = CALL_JMP;
            end
            CALL_JMP: begin
               ir_out     = 1'b1;
               pc_in      = 1'b1;
               next_state = FETCH_A;
            end
            HALT: begin
               halted     = 1'b1;
               next_state = HALT;
            end
            default: next_state = FETCH_A;
         endcase
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         illegal <= 1'b0;
      end else if ((state == DECODE) && is_illegal) begin
         illegal <= 1'b1;
      end
   end

`ifdef HMMM_CTRL_INSTRET_EN
   logic        retire;
   logic [15:0] instret;

   // Only the last state of a completed instruction hands back to FETCH_A; DECODE's illegal skip does not count.
   assign retire = (next_state == FETCH_A) &&
                   ((state == EXEC) || (state == MEM) || (state == ALU_WB) || (state == CALL_JMP));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         instret <= 16'h0000;
      end else if (retire) begin
         instret <= instret + 16'h0001;
      end
   end

   assign ctl.instret = instret;
`endif

   assign ctl.mem_req  = mem_req;
   assign ctl.mem_we   = mem_we;
   assign ctl.pc_out   = pc_out;
   assign ctl.pc_in    = pc_in;
   assign ctl.pc_inc   = pc_inc;
   assign ctl.mar_in   = mar_in;
   assign ctl.ir_in    = ir_in;
   assign ctl.ir_out   = ir_out;
   assign ctl.rf_out   = rf_out;
   assign ctl.rf_in    = rf_in;
   assign ctl.rf_sel   = rf_sel;
   assign ctl.alu_a_in = alu_a_in;
   assign ctl.alu_out  = alu_out;
   assign ctl.alu_op   = alu_op;
   assign ctl.halted   = halted;
   assign ctl.illegal  = illegal;

endmodule
